// File: rtl/fifo_tx_sequencer.sv
// fifo_tx_sequencer: drains a byte FIFO into a UART transmitter, one frame at a time,
// with a programmable idle gap after each completed frame.
// Ports: clk, rst (async active-low), en, gap_cycles, fifo_empty, fifo_rd_en,
//        fifo_data_out, tx_busy, tx_start, tx_data, sent_count, active.
module fifo_tx_sequencer #(
    parameter int WIDTH = 8,
    parameter int GAP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    output logic [CNT_W-1:0] sent_count,
    output logic             active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   sent_count_q, sent_count_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tx_data_q    <= '0;
            sent_count_q <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            sent_count_q <= sent_count_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        sent_count_d = sent_count_q;
        gap_cnt_d    = gap_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (en && !fifo_empty && !tx_busy) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // FIFO read data is registered: valid the cycle after the pop.
                tx_data_d = fifo_data_out;
                state_d   = S_START;
            end
            S_START: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent_count_d = sent_count_q + CNT_W'(1);
                    if (gap_cycles == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cycles;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                // Leave on the cycle the counter reads 1 so the gap is
                // exactly gap_cycles long.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded from the state register only.
    assign fifo_rd_en = (state_q == S_POP);
    assign tx_start   = (state_q == S_START);
    assign active     = (state_q != S_IDLE);
    assign tx_data    = tx_data_q;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
// tb_fifo_tx_sequencer: scoreboard bench with behavioural FIFO and UART models.
// Ports: none (top-level bench).
module tb_fifo_tx_sequencer;

    localparam int WIDTH = 8;
    localparam int GAP_W = 8;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [GAP_W-1:0] gap_cycles = '0;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic             tx_busy;
    logic             tx_start;
    logic [WIDTH-1:0] tx_data;
    logic [CNT_W-1:0] sent_count;
    logic             active;

    always #5 clk = ~clk;

    fifo_tx_sequencer #(
        .WIDTH(WIDTH),
        .GAP_W(GAP_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .gap_cycles   (gap_cycles),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .sent_count   (sent_count),
        .active       (active)
    );

    // Behavioural 16-deep FIFO with registered read data.
    logic [7:0] fq[$];
    int         fifo_cnt = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;

    always @(posedge clk) begin : fifo_model
        logic [7:0] t;
        if (fifo_rd_en && fq.size() > 0) begin
            t = fq.pop_front();
            fifo_data_out <= t;
        end
        if (wr_en && fq.size() < 16) fq.push_back(wr_data);
        fifo_cnt <= fq.size();
    end

    assign fifo_empty = (fifo_cnt == 0);

    // Transmitter model: busy for F cycles starting the cycle after tx_start.
    int   rem = 0;
    int   frames_done = 0;
    int   last_f = 0;
    int   fixed_f = 0;
    logic force_busy = 1'b0;

    always @(posedge clk or negedge rst) begin : tx_model
        int f;
        if (!rst) begin
            rem         <= 0;
            frames_done <= 0;
        end else if (tx_start) begin
            f = (fixed_f != 0) ? fixed_f : int'($urandom_range(3, 12));
            rem    <= f;
            last_f <= f;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) frames_done <= frames_done + 1;
        end
    end

    assign tx_busy = (rem != 0) || force_busy;

    // Scoreboard and counters.
    logic [7:0] exp_arr[4096];
    int exp_wr = 0;
    int exp_rd = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    bit burst = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_arr[exp_wr] = b;
        exp_wr++;
        step();
        wr_en = 1'b0;
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout, got no event expected one", name);
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fifo_cnt == 0 && !active && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_busy == lvl) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail(name);
    endtask

    // Monitor: compares every tx_start against the scoreboard and model.
    task automatic monitor();
        int  cyc = 0;
        int  last_rd = -100;
        int  last_start = 0;
        bit  prev_ok = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!burst) prev_ok = 1'b0;
            if (!rst) begin
                prev_ok = 1'b0;
            end else begin
                if (fifo_rd_en) begin
                    rd_cnt++;
                    chk("rd_while_empty", int'(fifo_empty), 0);
                    last_rd = cyc;
                end
                if (tx_start) begin
                    chk("rd_to_start_latency", cyc - last_rd, 2);
                    if (exp_rd < exp_wr) begin
                        chk("tx_data", int'(tx_data), int'(exp_arr[exp_rd]));
                        exp_rd++;
                    end else begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_start: got tx_start expected none");
                    end
                    chk("sent_count_at_start", int'(sent_count),
                        frames_done % CNT_MOD);
                    // Frame time = start cycle + busy cycles.
                    if (prev_ok)
                        chk("start_spacing", cyc - last_start,
                            last_f + 1 + int'(gap_cycles) + 4);
                    prev_ok    = burst;
                    last_start = cyc;
                end
            end
        end
    endtask

    task automatic run_burst(input int n, input int gap, input string name);
        int snap;
        en = 1'b0;
        for (int i = 0; i < n; i++) wr_byte(8'($urandom));
        gap_cycles = GAP_W'(gap);
        snap  = rd_cnt;
        burst = 1'b1;
        en    = 1'b1;
        drain(name, 4000);
        burst = 1'b0;
        chk({name, "_pops"}, rd_cnt - snap, n);
        chk({name, "_count"}, int'(sent_count), frames_done % CNT_MOD);
        step();
    endtask

    task automatic stimulus();
        int snap;
        repeat (3) step();
        chk("rst_rd_en", int'(fifo_rd_en), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_sent_count", int'(sent_count), 0);
        chk("rst_active", int'(active), 0);
        rst = 1'b1;
        step();

        // Reset in the middle of WAIT_DONE.
        fixed_f = 20;
        gap_cycles = '0;
        wr_byte(8'h5A);
        en = 1'b1;
        wait_busy(1'b1, "t1_busy");
        repeat (3) step();
        chk("t1_active_before", int'(active), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_rd_en", int'(fifo_rd_en), 0);
        chk("t1_tx_start", int'(tx_start), 0);
        chk("t1_tx_data", int'(tx_data), 0);
        chk("t1_sent_count", int'(sent_count), 0);
        chk("t1_active", int'(active), 0);
        step();
        step();
        rst = 1'b1;
        snap = rd_cnt;
        repeat (20) step();
        chk("t1_no_pop_empty", rd_cnt - snap, 0);

        // Single byte, no gap, 10-cycle frame.
        fixed_f = 10;
        wr_byte(8'hA5);
        wait_busy(1'b1, "t2_busy_hi");
        wait_busy(1'b0, "t2_busy_lo");
        step();
        chk("t2_active", int'(active), 0);
        chk("t2_sent_count", int'(sent_count), 1);
        fixed_f = 0;

        // Three bytes with a 5-cycle gap.
        en = 1'b0;
        wr_byte(8'h01);
        wr_byte(8'h02);
        wr_byte(8'h03);
        gap_cycles = 8'd5;
        snap  = rd_cnt;
        burst = 1'b1;
        en    = 1'b1;
        drain("t3_drain", 2000);
        burst = 1'b0;
        chk("t3_pops", rd_cnt - snap, 3);
        chk("t3_sent_count", int'(sent_count), 4);
        snap = rd_cnt;
        repeat (10) step();
        chk("t3_no_extra_pop", rd_cnt - snap, 0);

        // Full FIFO.
        run_burst(16, int'($urandom_range(0, 3)), "t4");

        // Drop en during byte 1 of 2.
        en = 1'b0;
        wr_byte(8'h11);
        wr_byte(8'h22);
        gap_cycles = 8'd2;
        snap = rd_cnt;
        en = 1'b1;
        wait_busy(1'b1, "t5_busy");
        step();
        en = 1'b0;
        for (int i = 0; i < 200 && active; i++) step();
        repeat (5) step();
        chk("t5_active", int'(active), 0);
        chk("t5_fifo_left", fifo_cnt, 1);
        chk("t5_pops", rd_cnt - snap, 1);
        chk("t5_sent_count", int'(sent_count), frames_done % CNT_MOD);
        en = 1'b1;
        drain("t5_drain", 2000);
        chk("t5_pops2", rd_cnt - snap, 2);

        // Transmitter owned elsewhere while data is queued.
        en = 1'b0;
        force_busy = 1'b1;
        wr_byte(8'h77);
        wr_byte(8'h88);
        snap = rd_cnt;
        en = 1'b1;
        repeat (20) step();
        chk("t6_no_pop_busy", rd_cnt - snap, 0);
        force_busy = 1'b0;
        drain("t6_drain", 2000);
        chk("t6_pops", rd_cnt - snap, 2);
        chk("t6_sent_count", int'(sent_count), frames_done % CNT_MOD);

        // Randomised bursts; sent_count wraps at 16 along the way.
        for (int p = 0; p < 6; p++)
            run_burst(int'($urandom_range(1, 10)),
                      int'($urandom_range(0, 6)), "rnd");

        chk("end_active", int'(active), 0);
        chk("end_scoreboard_empty", exp_rd, exp_wr);
        chk("end_sent_count", int'(sent_count), frames_done % CNT_MOD);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #5000000;
                n_cmp++;
                n_err++;
                $display("FAIL watchdog: got no completion expected finish");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
